arb_rr_fsm: RTL and testbench

Parametrised N-requester bus arbiter FSM, the successor to the two-requester fixed-priority grant FSM. It adds selectable fixed-priority or round-robin arbitration and a maximum-hold timeout that forces rotation under contention. Grant outputs are registered, one-hot, and sit between requesting masters and a shared resource.

---
 rtl/arb_rr_fsm.sv | 112 +++++++++++
 tb/tb_arb_rr_fsm.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/arb_rr_fsm.sv
// N-requester bus arbiter: fixed-priority or round-robin selection with a
// registered one-hot grant and a max-hold timeout that forces rotation under contention.
module arb_rr_fsm #(
  parameter int N_REQ    = 4,
  parameter int MAX_HOLD = 8,
  parameter int ID_W     = $clog2(N_REQ),
  parameter int CNT_W    = $clog2(MAX_HOLD) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic             mode,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_id,
  output logic             gnt_valid
);

  localparam logic IDLE  = 1'b0;
  localparam logic GRANT = 1'b1;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
  localparam logic [N_REQ-1:0] ONE_BIT   = N_REQ'(1);

  logic             state;
  logic [CNT_W-1:0] hold_cnt;
  logic [ID_W-1:0]  last_id;
  logic             grant_mode;

  logic [ID_W-1:0]  fp_win;
  logic [ID_W-1:0]  rr_win;
  logic             rr_found;
  logic [ID_W-1:0]  scan_idx;
  logic [ID_W-1:0]  winner;
  logic             others_req;
  logic             release_now;

  // Fixed priority: lowest set index wins, so scan downward and keep the last hit.
  always_comb begin
    fp_win = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        fp_win = ID_W'(i);
      end
    end
  end

  // Round robin: first set bit after the previous winner, wrapping modulo N_REQ.
  always_comb begin
    rr_win   = '0;
    rr_found = 1'b0;
    scan_idx = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      scan_idx = ID_W'((int'(last_id) + k) % N_REQ);
      if (!rr_found && req[scan_idx]) begin
        rr_win   = scan_idx;
        rr_found = 1'b1;
      end
    end
  end

  assign winner = mode ? rr_win : fp_win;

  // The timeout uses the mode latched at arbitration, so a mode change mid-grant waits for IDLE.
  assign others_req  = |(req & ~gnt);
  assign release_now = !req[gnt_id] ||
                       (grant_mode && (hold_cnt == HOLD_LAST) && others_req);

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      gnt        <= '0;
      gnt_id     <= '0;
      gnt_valid  <= 1'b0;
      hold_cnt   <= '0;
      last_id    <= ID_W'(N_REQ - 1);
      grant_mode <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          hold_cnt <= '0;
          if (|req) begin
            state      <= GRANT;
            gnt        <= ONE_BIT << winner;
            gnt_id     <= winner;
            gnt_valid  <= 1'b1;
            last_id    <= winner;
            grant_mode <= mode;
          end
        end
        GRANT: begin
          if (release_now) begin
            state     <= IDLE;
            gnt       <= '0;
            gnt_id    <= '0;
            gnt_valid <= 1'b0;
            hold_cnt  <= '0;
          end else if (hold_cnt != HOLD_LAST) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          gnt       <= '0;
          gnt_id    <= '0;
          gnt_valid <= 1'b0;
          hold_cnt  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arb_rr_fsm.sv
// Directed testbench for arb_rr_fsm with N_REQ=4, MAX_HOLD=4; expected grants are
// hand-computed per cycle and every comparison goes through checkOutput.
`timescale 1ns/1ps
module tb_arb_rr_fsm;

  localparam int N_REQ    = 4;
  localparam int MAX_HOLD = 4;
  localparam int ID_W     = $clog2(N_REQ);

  logic             clock;
  logic             reset;
  logic [N_REQ-1:0] req;
  logic             mode;
  logic [N_REQ-1:0] gnt;
  logic [ID_W-1:0]  gnt_id;
  logic             gnt_valid;

  int assertions;
  int failures;

  arb_rr_fsm #(
    .N_REQ(N_REQ),
    .MAX_HOLD(MAX_HOLD)
  ) dut (
    .clock(clock),
    .reset(reset),
    .req(req),
    .mode(mode),
    .gnt(gnt),
    .gnt_id(gnt_id),
    .gnt_valid(gnt_valid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assertions++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] expectedId(input logic [N_REQ-1:0] onehot);
    expectedId = 0;
    for (int i = 0; i < N_REQ; i++) begin
      if (onehot[i]) expectedId = i;
    end
  endfunction

  // Checks gnt, gnt_id and gnt_valid against one expected one-hot grant.
  task automatic checkGrant(input string tag, input logic [N_REQ-1:0] exp);
    checkOutput({tag, "_gnt"}, 32'(gnt), 32'(exp));
    checkOutput({tag, "_id"}, 32'(gnt_id), expectedId(exp));
    checkOutput({tag, "_valid"}, 32'(gnt_valid), 32'(|exp));
  endtask

  // Advance one rising edge and settle 1ns past it; inputs set afterwards land on the next edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic r, input logic m, input logic [N_REQ-1:0] q);
    reset = r;
    mode  = m;
    req   = q;
  endtask

  task automatic applyReset();
    applyStimulus(1'b1, 1'b0, '0);
    tick();
    tick();
    applyStimulus(1'b0, 1'b0, '0);
  endtask

  initial begin
    logic [N_REQ-1:0] order [5];
    assertions = 0;
    failures   = 0;
    applyStimulus(1'b1, 1'b0, 4'b1111);

    // 1. Reset holds grant off even with every request set
    tick();
    checkGrant("rst_c1", 4'b0000);
    tick();
    checkGrant("rst_c2", 4'b0000);
    reset = 1'b0;
    checkGrant("rst_release", 4'b0000);
    tick();
    checkGrant("rst_first_grant", 4'b0001);

    // 2. Fixed priority, owner drop, bubble, next owner
    applyReset();
    applyStimulus(1'b0, 1'b0, 4'b1010);
    for (int c = 0; c < 5; c++) begin
      tick();
      checkGrant("fp_hold", 4'b0010);
    end
    req = 4'b1000;
    tick();
    checkGrant("fp_bubble", 4'b0000);
    tick();
    checkGrant("fp_next", 4'b1000);

    // 3. Round-robin timeout rotation with one-cycle bubbles
    applyReset();
    applyStimulus(1'b0, 1'b1, 4'b1111);
    order[0] = 4'b0001;
    order[1] = 4'b0010;
    order[2] = 4'b0100;
    order[3] = 4'b1000;
    order[4] = 4'b0001;
    for (int o = 0; o < 5; o++) begin
      for (int c = 0; c < MAX_HOLD; c++) begin
        tick();
        checkGrant("rr_owner", order[o]);
      end
      tick();
      checkGrant("rr_bubble", 4'b0000);
    end

    // 4. Single requester in round-robin keeps the grant with no bubble
    applyReset();
    applyStimulus(1'b0, 1'b1, 4'b0100);
    for (int c = 0; c < 22; c++) begin
      tick();
      checkGrant("solo_hold", 4'b0100);
    end

    // 5. Fixed mode never times out; mode switch mid-grant waits for IDLE
    applyReset();
    applyStimulus(1'b0, 1'b0, 4'b1111);
    for (int c = 0; c < 22; c++) begin
      tick();
      checkGrant("fp_no_timeout", 4'b0001);
    end
    mode = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      checkGrant("mode_switch_hold", 4'b0001);
    end
    req = 4'b1110;
    tick();
    checkGrant("mode_switch_bubble", 4'b0000);
    tick();
    checkGrant("mode_switch_next", 4'b0010);

    // 6. Reset mid-grant clears grant and rotation pointer
    applyReset();
    applyStimulus(1'b0, 1'b1, 4'b1111);
    for (int c = 0; c < 10; c++) tick();
    tick();
    checkGrant("mid_owner2", 4'b0100);
    reset = 1'b1;
    tick();
    checkGrant("mid_reset", 4'b0000);
    reset = 1'b0;
    tick();
    checkGrant("mid_after_reset", 4'b0001);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
